demux1x2_4bit_stream: RTL and testbench



---
 rtl/demux1x2_4bit_stream.sv | 85 ++++++++
 tb/tb_demux1x2_4bit_stream.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_4bit_stream.sv
// Clocked 1-to-2 demultiplexer: each accepted word is steered by sel into one of
// two 2-entry FIFOs, each drained by its own valid/ready consumer.
module demux1x2_4bit_stream #(
    parameter int DEPTH = 2,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] D,
    input  logic         sel,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] ya,
    output logic         ya_valid,
    input  logic         ya_ready,
    output logic [W-1:0] yb,
    output logic         yb_valid,
    input  logic         yb_ready,
    output logic [1:0]   a_count,
    output logic [1:0]   b_count
);

    logic [1:0]   full;
    logic [1:0]   valid;
    logic [1:0]   ready;
    logic [1:0]   push;
    logic [1:0]   pop;
    logic [W-1:0] head [2];
    logic [1:0]   cnt  [2];

    assign ready = {yb_ready, ya_ready};

    // Acceptance looks only at registered occupancy, so a pop in the same
    // cycle never opens room for a push into a full channel.
    assign in_ready = ~rst & ~en & ~full[sel];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic [W-1:0] mem_reg [DEPTH];
            logic         rd_ptr_reg;
            logic         wr_ptr_reg;
            logic [1:0]   count_reg;

            assign push[gi]  = in_valid & in_ready & (sel == 1'(gi));
            assign pop[gi]   = valid[gi] & ready[gi];
            assign valid[gi] = (count_reg != 2'd0);
            assign full[gi]  = (count_reg == 2'd2);
            assign head[gi]  = mem_reg[rd_ptr_reg];
            assign cnt[gi]   = count_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                    rd_ptr_reg <= 1'b0;
                    wr_ptr_reg <= 1'b0;
                    count_reg  <= 2'd0;
                end else begin
                    if (push[gi]) begin
                        mem_reg[wr_ptr_reg] <= D;
                        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + 2'd1;
                        2'b01:   count_reg <= count_reg - 2'd1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    assign ya       = head[0];
    assign yb       = head[1];
    assign ya_valid = valid[0];
    assign yb_valid = valid[1];
    assign a_count  = cnt[0];
    assign b_count  = cnt[1];

endmodule

// File: tb/tb_demux1x2_4bit_stream.sv
// Directed bench for demux1x2_4bit_stream: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
module tb_demux1x2_4bit_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D;
    logic       sel;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] ya;
    logic       ya_valid;
    logic       ya_ready;
    logic [3:0] yb;
    logic       yb_valid;
    logic       yb_ready;
    logic [1:0] a_count;
    logic [1:0] b_count;

    int n_cmp = 0;
    int n_mis = 0;

    demux1x2_4bit_stream dut (
        .clk(clk), .rst(rst), .D(D), .sel(sel), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .ya(ya), .ya_valid(ya_valid), .ya_ready(ya_ready),
        .yb(yb), .yb_valid(yb_valid), .yb_ready(yb_ready),
        .a_count(a_count), .b_count(b_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; in_valid = 1'b1; D = 4'h7; sel = 1'b0;
        ya_ready = 1'b1; yb_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
            step();
            n_cmp++; if ({ya_valid, yb_valid} !== 2'b00) begin n_mis++; $display("FAIL rst_valids got %b want 00", {ya_valid, yb_valid}); end
            n_cmp++; if ({ya, yb} !== 8'h00) begin n_mis++; $display("FAIL rst_data got %h want 00", {ya, yb}); end
            n_cmp++; if ({a_count, b_count} !== 4'h0) begin n_mis++; $display("FAIL rst_counts got %h want 0", {a_count, b_count}); end
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
        n_cmp++; if ({a_count, b_count, ya_valid, yb_valid} !== 6'b0) begin n_mis++; $display("FAIL rst_release got %b want 000000", {a_count, b_count, ya_valid, yb_valid}); end
        $display("test_reset done");
    endtask

    task automatic test_alternate();
        ya_ready = 1'b1; yb_ready = 1'b1;
        in_valid = 1'b1; D = 4'h3; sel = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL alt_in_ready got %b want 1", in_ready); end
        step();
        n_cmp++; if ({ya_valid, ya} !== 5'h13) begin n_mis++; $display("FAIL alt_a3 got %h want 13", {ya_valid, ya}); end
        D = 4'hA; sel = 1'b1;
        step();
        n_cmp++; if ({yb_valid, yb} !== 5'h1A) begin n_mis++; $display("FAIL alt_bA got %h want 1a", {yb_valid, yb}); end
        n_cmp++; if ({ya_valid, a_count} !== 3'b000) begin n_mis++; $display("FAIL alt_a_drained got %b want 000", {ya_valid, a_count}); end
        D = 4'h5; sel = 1'b0;
        step();
        n_cmp++; if ({ya_valid, ya} !== 5'h15) begin n_mis++; $display("FAIL alt_a5 got %h want 15", {ya_valid, ya}); end
        n_cmp++; if ({yb_valid, b_count} !== 3'b000) begin n_mis++; $display("FAIL alt_b_drained got %b want 000", {yb_valid, b_count}); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (a_count !== 2'd0) begin n_mis++; $display("FAIL alt_end_a_count got %0d want 0", a_count); end
        $display("test_alternate done");
    endtask

    task automatic test_backpressure();
        ya_ready = 1'b0; yb_ready = 1'b1;
        in_valid = 1'b1; D = 4'h1; sel = 1'b0;
        step();
        n_cmp++; if ({a_count, ya} !== 6'h11) begin n_mis++; $display("FAIL bp_first got %h want 11", {a_count, ya}); end
        D = 4'h2;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL bp_second_ready got %b want 1", in_ready); end
        step();
        n_cmp++; if ({a_count, ya} !== 6'h21) begin n_mis++; $display("FAIL bp_full got %h want 21", {a_count, ya}); end
        D = 4'h4;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_third_blocked got %b want 0", in_ready); end
        D = 4'hF; sel = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL bp_other_chan_ready got %b want 1", in_ready); end
        step();
        n_cmp++; if ({yb_valid, yb, b_count, a_count} !== 9'b1_1111_01_10) begin n_mis++; $display("FAIL bp_bF got %b want 111110110", {yb_valid, yb, b_count, a_count}); end
        ya_ready = 1'b1; D = 4'h4; sel = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_no_bypass got %b want 0", in_ready); end
        step();
        n_cmp++; if ({a_count, ya, b_count} !== 8'b01_0010_00) begin n_mis++; $display("FAIL bp_pop1 got %b want 01001000", {a_count, ya, b_count}); end
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL bp_slot_freed got %b want 1", in_ready); end
        step();
        n_cmp++; if ({ya_valid, a_count, ya} !== 7'b1_01_0100) begin n_mis++; $display("FAIL bp_pop2_push4 got %b want 1010100", {ya_valid, a_count, ya}); end
        in_valid = 1'b0;
        step();
        n_cmp++; if ({ya_valid, a_count} !== 3'b000) begin n_mis++; $display("FAIL bp_end got %b want 000", {ya_valid, a_count}); end
        $display("test_backpressure done");
    endtask

    task automatic test_simul_push_pop();
        ya_ready = 1'b0; in_valid = 1'b1; D = 4'h6; sel = 1'b0;
        step();
        n_cmp++; if ({a_count, ya} !== 6'h16) begin n_mis++; $display("FAIL sim_setup got %h want 16", {a_count, ya}); end
        ya_ready = 1'b1; D = 4'h9;
        step();
        n_cmp++; if ({ya_valid, a_count, ya} !== 7'b1_01_1001) begin n_mis++; $display("FAIL sim_pushpop got %b want 1011001", {ya_valid, a_count, ya}); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (a_count !== 2'd0) begin n_mis++; $display("FAIL sim_end got %0d want 0", a_count); end
        $display("test_simul_push_pop done");
    endtask

    task automatic test_enable();
        ya_ready = 1'b0; yb_ready = 1'b0;
        in_valid = 1'b1; D = 4'h7; sel = 1'b0;
        step();
        D = 4'h8; sel = 1'b1;
        step();
        n_cmp++; if ({a_count, b_count} !== 4'b0101) begin n_mis++; $display("FAIL en_setup got %b want 0101", {a_count, b_count}); end
        en = 1'b1; D = 4'hC;
        for (int c = 0; c < 3; c++) begin
            sel = c[0];
            if (c == 2) begin ya_ready = 1'b1; yb_ready = 1'b1; end
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL en_blocked_%0d got %b want 0", c, in_ready); end
            step();
            if (c < 2) begin
                n_cmp++; if ({a_count, b_count, ya, yb} !== 12'b01_01_0111_1000) begin n_mis++; $display("FAIL en_hold_%0d got %b want 010101111000", c, {a_count, b_count, ya, yb}); end
            end else begin
                n_cmp++; if ({a_count, b_count, ya_valid, yb_valid} !== 6'b0) begin n_mis++; $display("FAIL en_drain got %b want 000000", {a_count, b_count, ya_valid, yb_valid}); end
            end
        end
        en = 1'b0; sel = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL en_resume_ready got %b want 1", in_ready); end
        step();
        n_cmp++; if ({ya_valid, a_count, ya} !== 7'b1_01_1100) begin n_mis++; $display("FAIL en_resume got %b want 1011100", {ya_valid, a_count, ya}); end
        in_valid = 1'b0;
        step();
        $display("test_enable done");
    endtask

    task automatic test_reset_mid();
        ya_ready = 1'b0; yb_ready = 1'b0; in_valid = 1'b1;
        D = 4'h1; sel = 1'b0; step();
        D = 4'h2; step();
        D = 4'h3; sel = 1'b1; step();
        n_cmp++; if ({a_count, b_count} !== 4'b1001) begin n_mis++; $display("FAIL rm_setup got %b want 1001", {a_count, b_count}); end
        rst = 1'b1; D = 4'hE;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL rm_in_ready got %b want 0", in_ready); end
        step();
        n_cmp++; if ({a_count, b_count, ya_valid, yb_valid, ya, yb} !== 14'b0) begin n_mis++; $display("FAIL rm_cleared got %b want 0", {a_count, b_count, ya_valid, yb_valid, ya, yb}); end
        rst = 1'b0; in_valid = 1'b0; ya_ready = 1'b1; yb_ready = 1'b1;
        step();
        n_cmp++; if ({a_count, b_count, ya_valid, yb_valid} !== 6'b0) begin n_mis++; $display("FAIL rm_no_reappear got %b want 000000", {a_count, b_count, ya_valid, yb_valid}); end
        $display("test_reset_mid done");
    endtask

    initial begin
        rst = 1'b1; D = 4'h0; sel = 1'b0; en = 1'b0; in_valid = 1'b0;
        ya_ready = 1'b0; yb_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_alternate();
        test_backpressure();
        test_simul_push_pop();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
